// File: rtl/service4_pkg.sv
// Shared types and constants for the alarm-clock service 4 block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package service4_pkg;

    // Alarm FSM encoding. Only these four codes are legal; any other value
    // is treated as corrupt state and recovers to S0.
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,   // idle
        S1 = 3'b001,   // ringing
        S2 = 3'b010,   // mini-game running
        S3 = 3'b100    // dismissed, waiting for the time code to move on
    } alarm_state_e;

    // Consecutive-correct counter as presented to the display.
    localparam int COUNT_W = 16;

    localparam logic [COUNT_W-1:0] C0 = 16'd0;
    localparam logic [COUNT_W-1:0] C1 = 16'd1;
    localparam logic [COUNT_W-1:0] C2 = 16'd2;
    localparam logic [COUNT_W-1:0] C3 = 16'd3;

    // Number of switches/LEDs in the mini-game.
    localparam int LED_WIDTH = 10;

endpackage

// File: rtl/service_4_minigame.sv
// Switch-matching mini-game: round timer plus consecutive-correct scoring.
// Latency: one round is scored every ROUND_CYCLES cycles; results registered.
// Backpressure: none; all inputs are level-sampled every cycle.
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   alarm_state          game-view state from the alarm FSM (S2 = play)
//   SPDTs, random_led    user switches and target LED pattern
//   count_state          consecutive-correct count (C0..WIN_COUNT)
//   mini_game            1 once WIN_COUNT rounds in a row were correct
//
// Optional build macro SERVICE4_NONZERO_MATCH_EN: when defined, an all-zero
// target pattern never counts as a correct round.
module service_4_minigame
    import service4_pkg::*;
#(
    parameter int LED_W        = LED_WIDTH,
    parameter int ROUND_CYCLES = 10,
    parameter int WIN_COUNT    = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [STATE_W-1:0] alarm_state,
    input  logic [LED_W-1:0]   SPDTs,
    input  logic [LED_W-1:0]   random_led,
    output logic [COUNT_W-1:0] count_state,
    output logic               mini_game
);

    localparam int               TMR_W    = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ROUND_CYCLES - 1);
    localparam logic [COUNT_W-1:0] WIN    = COUNT_W'(WIN_COUNT);

    logic [TMR_W-1:0]   timer_q,     timer_d;
    logic [COUNT_W-1:0] count_q,     count_d;
    logic               mini_game_q, mini_game_d;
    logic [COUNT_W-1:0] count_inc;
    logic               round_ok;

`ifdef SERVICE4_NONZERO_MATCH_EN
    assign round_ok = (SPDTs == random_led) && (random_led != '0);
`else
    assign round_ok = (SPDTs == random_led);
`endif

    assign count_inc = count_q + C1;

    always_comb begin
        timer_d     = '0;
        count_d     = C0;
        mini_game_d = 1'b0;
        case (alarm_state)
            S2: begin
                timer_d     = timer_q;
                count_d     = count_q;
                mini_game_d = mini_game_q;
                // Once won, the score is frozen: no more rounds are judged.
                if (!mini_game_q) begin
                    timer_d = (timer_q == TMR_LAST) ? '0 : timer_q + TMR_W'(1);
                    if (timer_q == TMR_LAST) begin
                        if (round_ok) begin
                            count_d = count_inc;
                            if (count_inc == WIN) begin
                                mini_game_d = 1'b1;
                            end
                        end else begin
                            count_d = C0;
                        end
                    end
                end
            end
            // The win flag stays visible to the UI while dismissed.
            S3:      mini_game_d = mini_game_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q     <= '0;
            count_q     <= C0;
            mini_game_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            count_q     <= count_d;
            mini_game_q <= mini_game_d;
        end
    end

    assign count_state = count_q;
    assign mini_game   = mini_game_q;

endmodule

// File: rtl/service_4_alarm_check.sv
// Alarm-clock service 4: ring on time match, dismiss by winning the mini-game.
// Latency: every state change is registered, one cycle after its trigger.
// Backpressure: none; all inputs are level-sampled every cycle.
//
// Ports:
//   clk, resetn        clock and asynchronous active-low reset
//   SPDT4              alarm enable (1 = armed); 0 forces idle and clears game
//   current, alarm     current time code and alarm set time code
//   push_m             debounced push button (acted on only while ringing)
//   SPDTs, random_led  mini-game switches and target pattern
//   alarm_state        S0=000 idle, S1=001 ring, S2=010 game, S3=100 dismissed
//   count_state        consecutive-correct count
//   mini_game          1 = mini-game won
//
// Optional build macro SERVICE4_NONZERO_MATCH_EN (see service_4_minigame).
module service_4_alarm_check
    import service4_pkg::*;
#(
    parameter int TIME_W       = 16,
    parameter int LED_W        = LED_WIDTH,
    parameter int ROUND_CYCLES = 10,
    parameter int WIN_COUNT    = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               SPDT4,
    input  logic [TIME_W-1:0]  current,
    input  logic [TIME_W-1:0]  alarm,
    input  logic               push_m,
    input  logic [LED_W-1:0]   SPDTs,
    input  logic [LED_W-1:0]   random_led,
    output logic [STATE_W-1:0] alarm_state,
    output logic [COUNT_W-1:0] count_state,
    output logic               mini_game
);

    alarm_state_e       state_q, state_d;
    logic [STATE_W-1:0] game_state;
    logic               time_hit;

    assign time_hit = (current == alarm);

    always_comb begin
        state_d = state_q;
        if (!SPDT4) begin
            state_d = S0;
        end else begin
            case (state_q)
                S0:      if (time_hit)  state_d = S1;
                S1:      if (push_m)    state_d = S2;
                S2:      if (mini_game) state_d = S3;
                S3:      if (!time_hit) state_d = S0;
                default:                state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // The scorer normally follows the current state, so the round timer runs
    // from the S2 entry edge. Whenever the FSM is heading to S0 (disarm,
    // dismiss or illegal code) it is shown S0 instead, so count, timer and
    // the win flag clear on that same edge rather than one cycle late.
    assign game_state = (state_d == S0) ? S0 : state_q;

    service_4_minigame #(
        .LED_W        (LED_W),
        .ROUND_CYCLES (ROUND_CYCLES),
        .WIN_COUNT    (WIN_COUNT)
    ) u_minigame (
        .clk         (clk),
        .resetn      (resetn),
        .alarm_state (game_state),
        .SPDTs       (SPDTs),
        .random_led  (random_led),
        .count_state (count_state),
        .mini_game   (mini_game)
    );

    assign alarm_state = state_q;

endmodule

// File: tb/tb_service_4_alarm_check.sv
module tb_service_4_alarm_check;

    localparam int RC  = 10;
    localparam int WIN = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        SPDT4;
    logic [15:0] current;
    logic [15:0] alarm;
    logic        push_m;
    logic [9:0]  SPDTs;
    logic [9:0]  random_led;
    logic [2:0]  alarm_state;
    logic [15:0] count_state;
    logic        mini_game;

    always #5 clk = ~clk;

    service_4_alarm_check #(
        .TIME_W       (16),
        .LED_W        (10),
        .ROUND_CYCLES (RC),
        .WIN_COUNT    (WIN)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .SPDT4       (SPDT4),
        .current     (current),
        .alarm       (alarm),
        .push_m      (push_m),
        .SPDTs       (SPDTs),
        .random_led  (random_led),
        .alarm_state (alarm_state),
        .count_state (count_state),
        .mini_game   (mini_game)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] cur;
        logic [2:0]  exp_state;
    } ramp_t;

    typedef struct {
        logic [9:0] sw;
        logic [9:0] led;
    } round_t;

    typedef struct {
        logic [15:0] cnt;
        logic        mini;
    } exp_t;

    ramp_t  ramp [21];
    round_t rounds_a [3];
    round_t rounds_b [3];
    round_t rounds_z [3];
    exp_t   sb [$];

    int   model_cnt;
    logic model_mini;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_game();
        model_cnt  = 0;
        model_mini = 1'b0;
    endtask

    // Drives one full round aligned to the scoring period, predicts the
    // outcome into the scoreboard and compares it at the scoring edge.
    task automatic play_round(input logic [9:0] sw, input logic [9:0] led, input string tag);
        exp_t        e;
        logic [15:0] prev;
        logic        ok;
        prev       = model_cnt[15:0];
        SPDTs      = sw;
        random_led = led;
        ok = (sw == led);
`ifdef SERVICE4_NONZERO_MATCH_EN
        ok = ok && (led != 10'd0);
`endif
        if (ok) begin
            model_cnt++;
            if (model_cnt == WIN) model_mini = 1'b1;
        end else begin
            model_cnt = 0;
        end
        e.cnt  = model_cnt[15:0];
        e.mini = model_mini;
        sb.push_back(e);
        tick(RC - 1);
        check({tag, " count before scoring edge"}, count_state, prev);
        tick(1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " count_state"}, count_state, e.cnt);
            check({tag, " mini_game"}, mini_game, e.mini);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected simulation to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] r;

        resetn     = 1'b0;
        SPDT4      = 1'b0;
        push_m     = 1'b0;
        current    = 16'd0;
        alarm      = 16'd10;
        SPDTs      = '0;
        random_led = '0;

        for (int i = 0; i < 21; i++) begin
            ramp[i].cur       = 16'(i);
            ramp[i].exp_state = (i >= 10) ? 3'b001 : 3'b000;
        end
        rounds_a[0] = '{10'b0000000001, 10'b0000000001};
        rounds_a[1] = '{10'b0000100000, 10'b0000100000};
        rounds_a[2] = '{10'b0000010000, 10'b0000100000};
        rounds_b[0] = '{10'b0000000100, 10'b0000000100};
        rounds_b[1] = '{10'b0000100000, 10'b0000100000};
        rounds_b[2] = '{10'b0010000000, 10'b0010000000};
        rounds_z[0] = '{10'd0, 10'd0};
        rounds_z[1] = '{10'h3FF, 10'h3FF};
        rounds_z[2] = '{10'd0, 10'd0};

        // Reset values
        #12;
        check("reset alarm_state", alarm_state, 3'b000);
        check("reset count_state", count_state, 16'd0);
        check("reset mini_game", mini_game, 1'b0);

        // Arm and ramp the time code through the alarm time
        @(negedge clk);
        resetn = 1'b1;
        SPDT4  = 1'b1;
        for (int i = 0; i < 21; i++) begin
            current = ramp[i].cur;
            tick(1);
            check($sformatf("ramp current=%0d state", i), alarm_state, ramp[i].exp_state);
        end

        // One-cycle button pulse starts the game
        push_m = 1'b1;
        tick(1);
        push_m = 1'b0;
        check("button state", alarm_state, 3'b010);
        check("button count", count_state, 16'd0);
        check("button mini", mini_game, 1'b0);

        // Streak broken, then a winning streak
        start_game();
        for (int i = 0; i < 3; i++) play_round(rounds_a[i].sw, rounds_a[i].led, $sformatf("streak%0d", i));
        current = 16'd10;
        for (int i = 0; i < 3; i++) play_round(rounds_b[i].sw, rounds_b[i].led, $sformatf("win%0d", i));
        check("win edge still S2", alarm_state, 3'b010);
        tick(1);
        check("dismissed state", alarm_state, 3'b100);
        check("dismissed mini", mini_game, 1'b1);
        tick(3);
        check("S3 hold while time matches", alarm_state, 3'b100);
        check("S3 count cleared", count_state, 16'd0);
        check("S3 mini held", mini_game, 1'b1);
        current = 16'd11;
        tick(1);
        check("leave S3 state", alarm_state, 3'b000);
        check("leave S3 mini", mini_game, 1'b0);
        check("leave S3 count", count_state, 16'd0);

        // Time hit and button together in S0: only S0->S1 at first
        current = 16'd10;
        push_m  = 1'b1;
        tick(1);
        check("hit+push first edge", alarm_state, 3'b001);
        tick(1);
        check("held push second edge", alarm_state, 3'b010);
        push_m = 1'b0;
        start_game();
        for (int i = 0; i < 2; i++) begin
            r = 10'($urandom_range(1, 1023));
            play_round(r, r, $sformatf("g2 round%0d", i));
        end
        SPDT4 = 1'b0;
        tick(1);
        check("disarm state", alarm_state, 3'b000);
        check("disarm count", count_state, 16'd0);
        check("disarm mini", mini_game, 1'b0);

        // Asynchronous reset mid-game
        SPDT4  = 1'b1;
        push_m = 1'b1;
        tick(2);
        push_m = 1'b0;
        check("g3 entered S2", alarm_state, 3'b010);
        start_game();
        for (int i = 0; i < 2; i++) begin
            r = 10'($urandom_range(1, 1023));
            play_round(r, r, $sformatf("g3 round%0d", i));
        end
        #2;
        resetn = 1'b0;
        #1;
        check("async reset state", alarm_state, 3'b000);
        check("async reset count", count_state, 16'd0);
        check("async reset mini", mini_game, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // All-zero target rounds
        push_m = 1'b1;
        tick(2);
        push_m = 1'b0;
        check("g4 entered S2", alarm_state, 3'b010);
        start_game();
        for (int i = 0; i < 3; i++) play_round(rounds_z[i].sw, rounds_z[i].led, $sformatf("zero%0d", i));
        SPDT4 = 1'b0;
        tick(1);
        check("final disarm state", alarm_state, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
